// File: rtl/fcb_pkg.sv
// Shared definitions for the frame capture buffer: FSM states,
// host register addresses and CTRL/STATUS bit positions.
package fcb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [2:0] REG_CTRL        = 3'd0;
  localparam logic [2:0] REG_STATUS      = 3'd1;
  localparam logic [2:0] REG_ADDR        = 3'd2;
  localparam logic [2:0] REG_DATA        = 3'd3;
  localparam logic [2:0] REG_FRAME_COUNT = 3'd4;
  localparam logic [2:0] REG_WINDOW      = 3'd5;

  localparam int CTRL_ARM   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_ABORT = 2;

  localparam int ST_DONE     = 2;
  localparam int ST_OVERRUN  = 3;
  localparam int ST_ADDR_ERR = 4;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port frame store: one write port, one read port with a
// single registered read stage. No reset so it maps onto block RAM.
module capture_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Pixel write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered host read port; holds its output between reads
  always_ff @(posedge clk) begin
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/frame_capture_buffer.sv
// Captures a rectangular window of a pixel stream into an on-chip buffer
// and exposes it, plus control/status, over an Avalon-MM register slave.
module frame_capture_buffer
  import fcb_pkg::*;
#(
  parameter int IMG_W    = 224,
  parameter int IMG_H    = 224,
  parameter int X0       = 208,
  parameter int Y0       = 128,
  parameter int PIX_W    = 8,
  parameter int CHANNELS = 1,
  parameter int COORD_W  = 11
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2:0]                addr,
  input  logic                      rd_en,
  input  logic                      wr_en,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic                      readdatavalid,
  input  logic                      pix_valid,
  input  logic                      pix_sof,
  input  logic [COORD_W-1:0]        pix_x,
  input  logic [COORD_W-1:0]        pix_y,
  input  logic [CHANNELS*PIX_W-1:0] pix_data,
  output logic                      irq
);

  localparam int unsigned N     = IMG_W * IMG_H;
  localparam int          IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int          DW    = CHANNELS * PIX_W;

  localparam logic [31:0]      X_LO     = 32'(X0);
  localparam logic [31:0]      X_HI     = 32'(X0 + IMG_W);
  localparam logic [31:0]      Y_LO     = 32'(Y0);
  localparam logic [31:0]      Y_HI     = 32'(Y0 + IMG_H);
  localparam logic [31:0]      W32      = 32'(IMG_W);
  localparam logic [31:0]      N32      = 32'(N);
  localparam logic [31:0]      LAST32   = 32'(N - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [31:0]      WINDOW_WORD = {16'(IMG_W), 16'(IMG_H)};

  if (CHANNELS < 1 || CHANNELS > 3 || CHANNELS * PIX_W > 32) begin : g_bad_cfg
    $error("frame_capture_buffer: CHANNELS must be 1..3 and CHANNELS*PIX_W <= 32");
  end

  state_t            state, state_next;
  logic              cont;
  logic [31:0]       addr_reg;
  logic [31:0]       frame_count;
  logic              done_flag, overrun, addr_err;
  logic              frame_pix, ram_we, frame_end, sof_overrun;
  logic              in_win;
  logic [31:0]       px, py;
  logic [IDX_W-1:0]  pix_idx;
  logic [DW-1:0]     ram_q;
  logic [31:0]       reg_word;
  logic              vld_p1, sel_data_p1, addr_ok_p1;
  logic [31:0]       rdata_p1;

  // Host access decode
  logic ctrl_wr, abort, arm, status_wr, addr_wr, data_rd, addr_in_range;
  assign ctrl_wr       = wr_en && (addr == REG_CTRL);
  assign abort         = ctrl_wr && writedata[CTRL_ABORT];
  assign arm           = ctrl_wr && writedata[CTRL_ARM] && !abort;
  assign status_wr     = wr_en && (addr == REG_STATUS);
  assign addr_wr       = wr_en && (addr == REG_ADDR);
  assign data_rd       = rd_en && (addr == REG_DATA);
  assign addr_in_range = addr_reg < N32;

  // Window test and linear buffer index; the index is only used in-window,
  // so the subtractions never underflow into a write
  assign px      = 32'(pix_x);
  assign py      = 32'(pix_y);
  assign in_win  = (px >= X_LO) && (px < X_HI) && (py >= Y_LO) && (py < Y_HI);
  assign pix_idx = IDX_W'((py - Y_LO) * W32 + (px - X_LO));

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM outputs: which pixels belong to the frame being captured
  always_comb begin
    frame_pix = 1'b0;
    case (state)
      WAIT_SOF: frame_pix = pix_valid && pix_sof;
      CAPTURE:  frame_pix = pix_valid;
      default:  frame_pix = 1'b0;
    endcase
    if (abort) frame_pix = 1'b0;
    ram_we      = frame_pix && in_win;
    frame_end   = ram_we && (pix_idx == LAST_IDX);
    sof_overrun = !abort && (state == CAPTURE) && pix_valid && pix_sof;
  end

  // FSM next state; abort dominates, arm is honoured only when not busy
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (arm) state_next = WAIT_SOF;
        WAIT_SOF: begin
          if (frame_pix) state_next = frame_end ? (cont ? WAIT_SOF : DONE) : CAPTURE;
        end
        CAPTURE: begin
          if (frame_end) state_next = cont ? WAIT_SOF : DONE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Continuous-mode latch, taken when an arm is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       cont <= 1'b0;
    else if (arm && (state == IDLE || state == DONE)) cont <= writedata[CTRL_CONT];
  end

  // Host buffer pointer: explicit writes beat the DATA-read post-increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          addr_reg <= '0;
    else if (addr_wr)                   addr_reg <= writedata;
    else if (data_rd && addr_in_range)  addr_reg <= (addr_reg == LAST32) ? '0 : addr_reg + 32'd1;
  end

  // Frame counter and sticky status flags; a new event beats a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
      done_flag   <= 1'b0;
      overrun     <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      if (frame_end) frame_count <= frame_count + 32'd1;
      if (status_wr) begin
        done_flag <= 1'b0;
        overrun   <= 1'b0;
        addr_err  <= 1'b0;
      end
      if (frame_end)                       done_flag <= 1'b1;
      if (sof_overrun)                     overrun   <= 1'b1;
      if (data_rd && !addr_in_range)       addr_err  <= 1'b1;
    end
  end

  // Register read mux on pre-write values
  always_comb begin
    reg_word = '0;
    case (addr)
      REG_CTRL:        reg_word = '0;
      REG_STATUS: begin
        reg_word[1:0]         = state;
        reg_word[ST_DONE]     = done_flag;
        reg_word[ST_OVERRUN]  = overrun;
        reg_word[ST_ADDR_ERR] = addr_err;
      end
      REG_ADDR:        reg_word = addr_reg;
      REG_DATA:        reg_word = '0;
      REG_FRAME_COUNT: reg_word = frame_count;
      REG_WINDOW:      reg_word = WINDOW_WORD;
      default:         reg_word = '0;
    endcase
  end

  // ---- read stage p0 -> p1: register response alongside the RAM read ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      sel_data_p1 <= 1'b0;
      addr_ok_p1  <= 1'b0;
      rdata_p1    <= '0;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en) begin
        sel_data_p1 <= (addr == REG_DATA);
        addr_ok_p1  <= addr_in_range;
        rdata_p1    <= reg_word;
      end
    end
  end

  capture_ram #(
    .DATA_W(DW),
    .ADDR_W(IDX_W),
    .DEPTH (N)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(pix_idx),
    .wdata(pix_data),
    .re   (data_rd),
    .raddr(addr_reg[IDX_W-1:0]),
    .q    (ram_q)
  );

  assign readdata      = sel_data_p1 ? (addr_ok_p1 ? 32'(ram_q) : 32'd0) : rdata_p1;
  assign readdatavalid = vld_p1;
  assign irq           = done_flag;

endmodule

// File: tb/tb_frame_capture_buffer.sv
// Bench for frame_capture_buffer with a 4x2 window at (2,1) on an 8x4 raster.
module tb_frame_capture_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  addr;
  logic        rd_en, wr_en;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        pix_valid, pix_sof;
  logic [10:0] pix_x, pix_y;
  logic [7:0]  pix_data;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  frame_capture_buffer #(
    .IMG_W(4), .IMG_H(2), .X0(2), .Y0(1), .PIX_W(8), .CHANNELS(1), .COORD_W(11)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .rd_en        (rd_en),
    .wr_en        (wr_en),
    .writedata    (writedata),
    .readdata     (readdata),
    .readdatavalid(readdatavalid),
    .pix_valid    (pix_valid),
    .pix_sof      (pix_sof),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_data     (pix_data),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  // Behavioural model of the register file and buffer
  int          m_state;
  bit          m_cont, m_done, m_ovr, m_err, m_rvld;
  int unsigned m_addr, m_fc;
  logic [31:0] m_rdata;
  logic [7:0]  m_mem [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cont = 0; m_addr = 0; m_fc = 0;
    m_done = 0; m_ovr = 0; m_err = 0; m_rvld = 0; m_rdata = 0;
  endtask

  // One clock edge of the model, applied to the inputs the DUT just sampled
  task automatic model_edge();
    int unsigned nxt_addr;
    bit set_err, abort, arm, clr, cap, win, complete;
    int px, py, idx;
    if (reset) return;
    nxt_addr = m_addr;
    set_err  = 0;
    m_rvld   = rd_en;
    if (rd_en) begin
      case (addr)
        3'd1: m_rdata = {27'd0, m_err, m_ovr, m_done, 2'(m_state)};
        3'd2: m_rdata = m_addr;
        3'd3: begin
          if (m_addr < 8) begin
            m_rdata  = {24'd0, m_mem[m_addr]};
            nxt_addr = (m_addr + 1) % 8;
          end else begin
            m_rdata = 0;
            set_err = 1;
          end
        end
        3'd4: m_rdata = m_fc;
        3'd5: m_rdata = {16'd4, 16'd2};
        default: m_rdata = 0;
      endcase
    end
    abort = wr_en && addr == 3'd0 && writedata[2];
    arm   = wr_en && addr == 3'd0 && writedata[0] && !abort;
    clr   = wr_en && addr == 3'd1;
    if (wr_en && addr == 3'd2) nxt_addr = writedata;
    px  = int'(pix_x);
    py  = int'(pix_y);
    win = px >= 2 && px < 6 && py >= 1 && py < 3;
    cap = !abort && pix_valid && ((m_state == 1 && pix_sof) || m_state == 2);
    idx = (py - 1) * 4 + (px - 2);
    complete = 0;
    if (cap && win) begin
      m_mem[idx] = pix_data;
      complete   = (idx == 7);
    end
    if (clr) begin m_done = 0; m_ovr = 0; m_err = 0; end
    if (complete) begin m_done = 1; m_fc++; end
    if (!abort && m_state == 2 && pix_valid && pix_sof) m_ovr = 1;
    if (set_err) m_err = 1;
    if (abort) m_state = 0;
    else if (arm && (m_state == 0 || m_state == 3)) begin
      m_state = 1;
      m_cont  = writedata[1];
    end else if (cap) m_state = complete ? (m_cont ? 1 : 3) : 2;
    m_addr = nxt_addr;
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("rdvalid", 32'(readdatavalid), 32'(m_rvld));
    if (m_rvld) check("readdata", readdata, m_rdata);
    check("irq", 32'(irq), 32'(m_done));
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    #3;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    addr = a; writedata = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    addr = a; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    d = readdata;
  endtask

  task automatic rdwr(input logic [2:0] a, input logic [31:0] wd, output logic [31:0] d);
    addr = a; writedata = wd; rd_en = 1'b1; wr_en = 1'b1;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    d = readdata;
  endtask

  // Raster scan of the 8x4 frame, stopping after `limit` window pixels
  task automatic scan(input logic [7:0] off, input int limit);
    int nwin = 0;
    for (int y = 0; y < 4 && nwin < limit; y++) begin
      for (int x = 0; x < 8 && nwin < limit; x++) begin
        pix_valid = 1'b1;
        pix_sof   = (x == 0 && y == 0);
        pix_x     = 11'(x);
        pix_y     = 11'(y);
        pix_data  = 8'(16 * y + x) + off;
        tick();
        if (x >= 2 && x < 6 && y >= 1 && y < 3) nwin++;
      end
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic read_frame(input string tag);
    logic [31:0] d;
    logic [7:0] exp_tab [8];
    exp_tab = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h22, 8'h23, 8'h24, 8'h25};
    wr(3'd2, 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd(3'd3, d);
      check($sformatf("%s_data%0d", tag, i), d, {24'd0, exp_tab[i]});
    end
    rd(3'd2, d);
    check({tag, "_addr_wrap"}, d, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    reset = 1'b1; addr = '0; rd_en = 1'b0; wr_en = 1'b0; writedata = '0;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_x = '0; pix_y = '0; pix_data = '0;
    model_reset();
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdvalid", 32'(readdatavalid), 32'd0);
    rd(3'd1, d); check("rst_status", d, 32'd0);
    rd(3'd4, d); check("rst_fcount", d, 32'd0);
    rd(3'd2, d); check("rst_addr", d, 32'd0);
    rd(3'd5, d); check("window", d, 32'h0004_0002);
    rd(3'd6, d); check("reg6", d, 32'd0);

    // Scenario 1: single frame
    wr(3'd0, 32'h1);
    rd(3'd1, d); check("s1_wait_sof", d, 32'h1);
    scan(8'h00, 99);
    rd(3'd1, d); check("s1_status", d, 32'h7);
    check("s1_irq", 32'(irq), 32'd1);
    rd(3'd4, d); check("s1_fcount", d, 32'd1);
    read_frame("s1");

    // Scenario 2: continuous capture then abort; abort beats arm
    do_reset();
    wr(3'd0, 32'h3);
    scan(8'h00, 99); scan(8'h00, 99); scan(8'h00, 99);
    rd(3'd4, d); check("s2_fcount", d, 32'd3);
    rd(3'd1, d); check("s2_status", d, 32'h5);
    wr(3'd0, 32'h4);
    rd(3'd1, d); check("s2_abort", d, 32'h4);
    wr(3'd0, 32'h5);
    rd(3'd1, d); check("s2_abort_wins", d, 32'h4);

    // Scenario 3: early SOF overrun; arm while waiting is ignored
    do_reset();
    wr(3'd0, 32'h1);
    wr(3'd0, 32'h3);
    scan(8'h00, 5);
    scan(8'h00, 99);
    rd(3'd1, d); check("s3_status", d, 32'hF);
    rd(3'd4, d); check("s3_fcount", d, 32'd1);
    wr(3'd1, 32'h0);
    rd(3'd1, d); check("s3_cleared", d, 32'h3);
    check("s3_irq", 32'(irq), 32'd0);

    // Scenario 4: out-of-range pointer
    wr(3'd2, 32'd8);
    rd(3'd3, d); check("s4_data", d, 32'd0);
    rd(3'd1, d); check("s4_status", d, 32'h13);
    rd(3'd2, d); check("s4_addr", d, 32'd8);

    // Scenario 5: same-cycle read and write see pre-write values
    wr(3'd2, 32'd3);
    rdwr(3'd2, 32'd6, d); check("s5_pre_addr", d, 32'd3);
    rd(3'd2, d); check("s5_new_addr", d, 32'd6);
    rd(3'd3, d); check("s5_data6", d, 32'h24);
    rd(3'd2, d); check("s5_inc", d, 32'd7);
    rdwr(3'd1, 32'd0, d); check("s5_pre_status", d, 32'h13);
    rd(3'd1, d); check("s5_post_status", d, 32'h3);

    // Scenario 6: reset mid-capture
    wr(3'd0, 32'h1);
    scan(8'h00, 99);
    rd(3'd4, d); check("s6_fcount", d, 32'd2);
    wr(3'd0, 32'h1);
    scan(8'h80, 3);
    reset = 1'b1;
    model_reset();
    #1;
    check("s6_rst_irq", 32'(irq), 32'd0);
    check("s6_rst_rdata", readdata, 32'd0);
    check("s6_rst_rdvalid", 32'(readdatavalid), 32'd0);
    tick();
    reset = 1'b0;
    rd(3'd1, d); check("s6_status", d, 32'd0);
    rd(3'd4, d); check("s6_fcount0", d, 32'd0);
    rd(3'd3, d); check("s6_partial", d, 32'h92);
    wr(3'd0, 32'h1);
    scan(8'h00, 99);
    rd(3'd1, d); check("s6_done", d, 32'h7);
    read_frame("s6");

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
